// File: rtl/mult_issue_queue.sv
// -----------------------------------------------------------------------------
// mult_issue_queue
//
// In-order issue queue for the multiplier path. Sits between the dispatch
// generator and the multiply execution unit. Accepts at most one entry per
// cycle, holds entries until both source operands are valid, snoops the CDB
// to capture pending operands, and issues the head entry through a
// valid/ready handshake.
//
// Ports:
//   clk              system clock, rising-edge active
//   rst              asynchronous active-high reset
//   mult_dispatch_en dispatch request from the dispatch generator
//   i_mult_fifo_data common_fifo_data: {rs1_data[32], rs2_data[32],
//                    rs1_tag[6], rs2_tag[6], rd_tag[6], rs1_data_valid,
//                    rs2_data_valid} (MSB first)
//   cdb_valid        CDB broadcast valid this cycle
//   cdb_tag          tag of the broadcast result
//   cdb_data         value of the broadcast result
//   exec_ready       multiplier can accept an operation this cycle
//   o_full           DEPTH entries held; upstream must stall dispatch
//   o_empty          no entries held
//   o_count          current occupancy, 0..DEPTH
//   o_issue_valid    head entry is ready to issue
//   o_issue_data     head entry with captured operands
// -----------------------------------------------------------------------------
module mult_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_dispatch_en,
    input  logic [83:0]      i_mult_fifo_data,
    input  logic             cdb_valid,
    input  logic [5:0]       cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             exec_ready,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    output logic             o_issue_valid,
    output logic [83:0]      o_issue_data
);

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [5:0]  rs1_tag;
        logic [5:0]  rs2_tag;
        logic [5:0]  rd_tag;
        logic        rs1_data_valid;
        logic        rs2_data_valid;
    } entry_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    // Apply one CDB broadcast to an entry: each pending source whose tag
    // matches takes the broadcast value. Both sources may match at once.
    function automatic entry_t snoop(input entry_t e, input logic cv,
                                     input logic [5:0] ct, input logic [31:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.rs1_data_valid && (e.rs1_tag == ct)) begin
            r.rs1_data       = cd;
            r.rs1_data_valid = 1'b1;
        end
        if (cv && !e.rs2_data_valid && (e.rs2_tag == ct)) begin
            r.rs2_data       = cd;
            r.rs2_data_valid = 1'b1;
        end
        return r;
    endfunction

    entry_t             entry_reg [DEPTH];
    logic [DEPTH-1:0]   valid_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [PTR_W:0]     count_next;

    entry_t             head;
    entry_t             incoming;
    logic               accept;
    logic               fire;
    logic [DEPTH-1:0]   write_hit;
    logic [DEPTH-1:0]   fire_hit;

    assign incoming = i_mult_fifo_data;
    assign head     = entry_reg[rd_ptr_reg];

    // Full/empty come from the occupancy counter, never from pointer equality.
    assign o_full        = (count_reg == FULL_COUNT);
    assign o_empty       = (count_reg == '0);
    assign o_count       = count_reg;
    assign o_issue_valid = valid_reg[rd_ptr_reg] & head.rs1_data_valid & head.rs2_data_valid;
    assign o_issue_data  = head;

    assign accept = mult_dispatch_en & ~o_full;
    assign fire   = o_issue_valid & exec_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_hit
            assign write_hit[gi] = accept && (wr_ptr_reg == PTR_W'(gi));
            assign fire_hit[gi]  = fire   && (rd_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({accept, fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Control state: valid bits, pointers, count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_hit[i]) begin
                    valid_reg[i] <= 1'b1;
                end else if (fire_hit[i]) begin
                    valid_reg[i] <= 1'b0;
                end
            end
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Entry payloads need no reset: nothing reads a slot whose valid bit is
    // clear. A slot being written is never valid (accept requires a free
    // slot), so the write and snoop branches never compete. The firing head
    // is left untouched; being ready it has no pending source anyway.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_hit[i]) begin
                entry_reg[i] <= snoop(incoming, cdb_valid, cdb_tag, cdb_data);
            end else if (valid_reg[i] && !fire_hit[i]) begin
                entry_reg[i] <= snoop(entry_reg[i], cdb_valid, cdb_tag, cdb_data);
            end
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_mult_issue_queue
//
// Self-checking bench for mult_issue_queue: a table of directed cycles,
// hand-written multi-cycle sequences, then randomized traffic. Every cycle is
// also compared against a queue-based reference model of the issue queue.
// -----------------------------------------------------------------------------
module tb_mult_issue_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [5:0]  rs1_tag;
        logic [5:0]  rs2_tag;
        logic [5:0]  rd_tag;
        logic        rs1_data_valid;
        logic        rs2_data_valid;
    } entry_t;

    typedef struct {
        logic           en;
        entry_t         ent;
        logic           er;
        logic [PTR_W:0] exp_count;
        logic           exp_full;
        logic           exp_iv;
        logic [5:0]     exp_rd;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             mult_dispatch_en;
    logic [83:0]      i_mult_fifo_data;
    logic             cdb_valid;
    logic [5:0]       cdb_tag;
    logic [31:0]      cdb_data;
    logic             exec_ready;
    logic             o_full;
    logic             o_empty;
    logic [PTR_W:0]   o_count;
    logic             o_issue_valid;
    logic [83:0]      o_issue_data;
    entry_t           dut_head;

    int checks = 0;
    int errors = 0;

    entry_t mq[$];   // reference model: oldest entry at index 0

    assign dut_head = o_issue_data;

    mult_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .mult_dispatch_en (mult_dispatch_en),
        .i_mult_fifo_data (i_mult_fifo_data),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .exec_ready       (exec_ready),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_count          (o_count),
        .o_issue_valid    (o_issue_valid),
        .o_issue_data     (o_issue_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [5:0] t1, input logic [5:0] t2,
                                  input logic [5:0] rd, input logic v1, input logic v2);
        entry_t e;
        e.rs1_data = d1;  e.rs2_data = d2;
        e.rs1_tag = t1;   e.rs2_tag = t2;  e.rd_tag = rd;
        e.rs1_data_valid = v1;  e.rs2_data_valid = v2;
        return e;
    endfunction

    // A broadcast fills any pending source whose tag it carries.
    function automatic entry_t model_snoop(input entry_t e, input logic cv,
                                           input logic [5:0] ct, input logic [31:0] cd);
        entry_t r;
        r = e;
        if (cv && !r.rs1_data_valid && r.rs1_tag == ct) begin
            r.rs1_data = cd; r.rs1_data_valid = 1'b1;
        end
        if (cv && !r.rs2_data_valid && r.rs2_tag == ct) begin
            r.rs2_data = cd; r.rs2_data_valid = 1'b1;
        end
        return r;
    endfunction

    function automatic logic model_iv();
        return (mq.size() > 0) && mq[0].rs1_data_valid && mq[0].rs2_data_valid;
    endfunction

    task automatic check_model();
        chk("model_count", 84'(o_count), 84'(mq.size()));
        chk("model_full",  84'(o_full),  84'(mq.size() == DEPTH));
        chk("model_empty", 84'(o_empty), 84'(mq.size() == 0));
        chk("model_issue_valid", 84'(o_issue_valid), 84'(model_iv()));
        if (mq.size() > 0) begin
            chk("model_head", o_issue_data, mq[0]);
        end
    endtask

    task automatic set_in(input logic en, input entry_t e, input logic cv,
                          input logic [5:0] ct, input logic [31:0] cd, input logic er);
        mult_dispatch_en = en;
        i_mult_fifo_data = e;
        cdb_valid        = cv;
        cdb_tag          = ct;
        cdb_data         = cd;
        exec_ready       = er;
    endtask

    // One clock cycle: check outputs against the model, advance the model by
    // the queue's rules, then let the DUT take the edge.
    task automatic step();
        logic   m_fire;
        logic   m_acc;
        entry_t in_e;
        check_model();
        m_fire = model_iv() && exec_ready;
        m_acc  = mult_dispatch_en && (mq.size() < DEPTH);
        in_e   = i_mult_fifo_data;
        @(posedge clk);
        if (m_fire) void'(mq.pop_front());
        foreach (mq[i]) mq[i] = model_snoop(mq[i], cdb_valid, cdb_tag, cdb_data);
        if (m_acc) mq.push_back(model_snoop(in_e, cdb_valid, cdb_tag, cdb_data));
        #1;
        $display("cycle t=%0t en=%0b er=%0b cdb=%0b/%0h count=%0d iv=%0b rd=%0h",
                 $time, mult_dispatch_en, exec_ready, cdb_valid, cdb_tag,
                 o_count, o_issue_valid, dut_head.rd_tag);
    endtask

    entry_t idle_e;
    vec_t   vecs[11];

    initial begin
        idle_e = mk(32'd0, 32'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);

        // Test plan 1 and 2 as a per-cycle table (expected values after the edge).
        vecs[0]  = '{1'b1, mk(32'd3, 32'd5, 6'd0, 6'd0, 6'h0A, 1'b1, 1'b1), 1'b1, 3'd1, 1'b0, 1'b1, 6'h0A};
        vecs[1]  = '{1'b0, idle_e, 1'b1, 3'd0, 1'b0, 1'b0, 6'h00};
        vecs[2]  = '{1'b1, mk(32'd10, 32'd20, 6'd0, 6'd0, 6'h10, 1'b1, 1'b1), 1'b0, 3'd1, 1'b0, 1'b1, 6'h10};
        vecs[3]  = '{1'b1, mk(32'd11, 32'd21, 6'd0, 6'd0, 6'h11, 1'b1, 1'b1), 1'b0, 3'd2, 1'b0, 1'b1, 6'h10};
        vecs[4]  = '{1'b1, mk(32'd12, 32'd22, 6'd0, 6'd0, 6'h12, 1'b1, 1'b1), 1'b0, 3'd3, 1'b0, 1'b1, 6'h10};
        vecs[5]  = '{1'b1, mk(32'd13, 32'd23, 6'd0, 6'd0, 6'h13, 1'b1, 1'b1), 1'b0, 3'd4, 1'b1, 1'b1, 6'h10};
        vecs[6]  = '{1'b1, mk(32'd14, 32'd24, 6'd0, 6'd0, 6'h14, 1'b1, 1'b1), 1'b0, 3'd4, 1'b1, 1'b1, 6'h10};
        vecs[7]  = '{1'b0, idle_e, 1'b1, 3'd3, 1'b0, 1'b1, 6'h11};
        vecs[8]  = '{1'b0, idle_e, 1'b1, 3'd2, 1'b0, 1'b1, 6'h12};
        vecs[9]  = '{1'b0, idle_e, 1'b1, 3'd1, 1'b0, 1'b1, 6'h13};
        vecs[10] = '{1'b0, idle_e, 1'b1, 3'd0, 1'b0, 1'b0, 6'h00};

        rst = 1'b1;
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b0);
        #12;
        chk("reset_count", 84'(o_count), 84'd0);
        chk("reset_empty", 84'(o_empty), 84'd1);
        chk("reset_full",  84'(o_full),  84'd0);
        chk("reset_issue_valid", 84'(o_issue_valid), 84'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven directed cycles.
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].en, vecs[i].ent, 1'b0, 6'd0, 32'd0, vecs[i].er);
            step();
            chk($sformatf("vec%0d_count", i), 84'(o_count), 84'(vecs[i].exp_count));
            chk($sformatf("vec%0d_full", i),  84'(o_full),  84'(vecs[i].exp_full));
            chk($sformatf("vec%0d_iv", i),    84'(o_issue_valid), 84'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                chk($sformatf("vec%0d_rd_tag", i), 84'(dut_head.rd_tag), 84'(vecs[i].exp_rd));
            end
        end
        chk("after_fill_empty", 84'(o_empty), 84'd1);

        // CDB capture on a resident entry.
        set_in(1'b1, mk(32'h1111, 32'h2222, 6'h12, 6'h00, 6'h21, 1'b0, 1'b1), 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("cap_wait_iv0", 84'(o_issue_valid), 84'd0);
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("cap_wait_iv1", 84'(o_issue_valid), 84'd0);
        set_in(1'b0, idle_e, 1'b1, 6'h12, 32'hDEADBEEF, 1'b1);
        step();
        chk("cap_iv", 84'(o_issue_valid), 84'd1);
        chk("cap_rs1_data", 84'(dut_head.rs1_data), 84'(32'hDEADBEEF));
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("cap_drained", 84'(o_empty), 84'd1);

        // Same-cycle dispatch and broadcast.
        set_in(1'b1, mk(32'd7, 32'hFFFF, 6'h00, 6'h07, 6'h22, 1'b1, 1'b0), 1'b1, 6'h07, 32'd42, 1'b0);
        step();
        chk("bypass_iv", 84'(o_issue_valid), 84'd1);
        chk("bypass_rs2_data", 84'(dut_head.rs2_data), 84'd42);
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("bypass_drained", 84'(o_empty), 84'd1);

        // Head-of-line blocking.
        set_in(1'b1, mk(32'd0, 32'd9, 6'h01, 6'h00, 6'h31, 1'b0, 1'b1), 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        set_in(1'b1, mk(32'd4, 32'd8, 6'h00, 6'h00, 6'h32, 1'b1, 1'b1), 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("hol_blocked_iv", 84'(o_issue_valid), 84'd0);
        chk("hol_blocked_count", 84'(o_count), 84'd2);
        set_in(1'b0, idle_e, 1'b1, 6'h01, 32'h55, 1'b1);
        step();
        chk("hol_a_ready", 84'(o_issue_valid), 84'd1);
        chk("hol_a_rd", 84'(dut_head.rd_tag), 84'(6'h31));
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("hol_b_rd", 84'(dut_head.rd_tag), 84'(6'h32));
        chk("hol_b_iv", 84'(o_issue_valid), 84'd1);
        step();
        chk("hol_drained", 84'(o_empty), 84'd1);

        // Simultaneous accept/fire at count 2, then asynchronous reset.
        set_in(1'b1, mk(32'd1, 32'd1, 6'd0, 6'd0, 6'h41, 1'b1, 1'b1), 1'b0, 6'd0, 32'd0, 1'b0);
        step();
        set_in(1'b1, mk(32'd2, 32'd2, 6'd0, 6'd0, 6'h42, 1'b1, 1'b1), 1'b0, 6'd0, 32'd0, 1'b0);
        step();
        chk("simul_pre_count", 84'(o_count), 84'd2);
        set_in(1'b1, mk(32'd3, 32'd3, 6'd0, 6'd0, 6'h43, 1'b1, 1'b1), 1'b0, 6'd0, 32'd0, 1'b1);
        step();
        chk("simul_count", 84'(o_count), 84'd2);
        chk("simul_head_rd", 84'(dut_head.rd_tag), 84'(6'h42));
        set_in(1'b0, idle_e, 1'b0, 6'd0, 32'd0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 84'(o_count), 84'd0);
        chk("async_rst_iv", 84'(o_issue_valid), 84'd0);
        chk("async_rst_empty", 84'(o_empty), 84'd1);
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Randomized traffic against the model; small tag space keeps
        // broadcasts hitting pending sources often.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 99) < 60,
                   mk($urandom, $urandom, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                      6'($urandom_range(0, 63)), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60),
                   $urandom_range(0, 99) < 50, 6'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 60);
            step();
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
- In-order issue queue for the multiplier path. It sits directly downstream of the dispatch generator and upstream of the multiply execution unit.
- Each cycle it accepts at most one dispatched multiply entry (common_fifo_data) and holds it until both source operands are valid.
- While entries wait, it snoops the common data bus (CDB) to capture pending operands.
- It issues the head entry to the multiplier through a valid/ready handshake.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of 2 and >= 2.
- PTR_W, $clog2(DEPTH): width of the read/write pointers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mult_dispatch_en  input  1  dispatch request from the dispatch generator.
- i_mult_fifo_data  input  84  common_fifo_data: rs1_data[32], rs2_data[32], rs1_tag[6], rs2_tag[6], rd_tag[6], rs1_data_valid, rs2_data_valid.
- cdb_valid  input  1  a CDB broadcast is valid this cycle.
- cdb_tag  input  6  tag of the result being broadcast.
- cdb_data  input  32  value of the result being broadcast.
- exec_ready  input  1  the multiplier can accept an operation this cycle.
- o_full  output  1  queue holds DEPTH entries; upstream must stall dispatch.
- o_empty  output  1  queue holds 0 entries.
- o_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- o_issue_valid  output  1  the head entry is ready to issue.
- o_issue_data  output  84  head entry (common_fifo_data), with captured operands.

Behaviour:
- **Reset.** rst=1 asynchronously clears all entry valid bits, both pointers and the count. Outputs during reset: o_full=0, o_empty=1, o_count=0, o_issue_valid=0. o_issue_data is don't-care while the queue is empty. A reset mid-operation discards every entry with no issue.
- **Dispatch accept.**
  - accept = mult_dispatch_en & ~o_full, where o_full is registered state.
  - On accept, the entry is written at wr_ptr, its valid bit is set, and wr_ptr increments modulo DEPTH.
  - A dispatch while o_full=1 is ignored: no state change, no error flag. Holding the request is upstream's responsibility.
- **Issue fire.**
  - o_issue_valid = head valid & head rs1_data_valid & head rs2_data_valid. It depends on registered state only; there is no combinational path from the CDB.
  - fire = o_issue_valid & exec_ready.
  - On fire, the head valid bit clears and rd_ptr increments modulo DEPTH.
- **Count.** o_count is +1 on accept-only, -1 on fire-only, and unchanged on both or neither. o_full = (count==DEPTH); o_empty = (count==0).
- **Same-cycle accept and fire when full.** This cannot accept, because o_full gates accept. The fire proceeds and o_full drops on the next cycle.
- **Pointer wrap.** Pointers wrap naturally at DEPTH. Full versus empty is decided from count, never from pointer equality.
- **CDB snoop on resident entries.** For every valid entry and each source X in {rs1, rs2}: if rsX_data_valid=0 and cdb_valid=1 and cdb_tag==rsX_tag, then on that edge rsX_data<=cdb_data and rsX_data_valid<=1. Both sources of one entry may capture on the same edge.
- **CDB snoop on the entry being dispatched.** The same match is applied to the incoming i_mult_fifo_data, so the entry is written already-captured. No broadcast is ever missed.
- **Fire/capture on the same entry.** If the head fires, its stored data is not modified on that edge. This cannot conflict, because a ready head has no pending source.
- **Latency.**
  - An entry accepted at edge N with both sources valid can have o_issue_valid=1 in cycle N+1.
  - A head source captured from the CDB at edge M makes o_issue_valid=1 in cycle M+1.
- **Ordering.** Issue order is strictly dispatch order. A non-ready head blocks younger ready entries.
- **Backpressure.** With exec_ready=0, o_issue_valid and o_issue_data hold stable until a fire occurs.

Test Plan:
1. **Reset and basic pass-through.**
   - Stimulus: rst pulse, then dispatch {rs1_data=3, rs2_data=5, both valid, rd_tag=6'h0A} with exec_ready=1.
   - Required: next cycle o_issue_valid=1 with rd_tag=0x0A; one cycle later o_empty=1, o_count=0.
2. **Fill to full.**
   - Stimulus: exec_ready=0, 5 consecutive dispatches.
   - Required: o_count=4, o_full=1; the 5th dispatch is dropped.
   - Then, with exec_ready=1: entries issue in dispatch order over 4 cycles and o_count returns to 0.
3. **CDB capture on a resident entry.**
   - Stimulus: dispatch with rs1_tag=6'h12, rs1_data_valid=0.
   - Required: o_issue_valid stays 0.
   - Stimulus: cdb_valid=1, cdb_tag=0x12, cdb_data=0xDEADBEEF.
   - Required: next cycle o_issue_valid=1 and o_issue_data.rs1_data=0xDEADBEEF.
4. **Same-cycle dispatch/CDB bypass.**
   - Stimulus: dispatch with rs2_tag=0x07 pending, while cdb_tag=0x07 and cdb_data=42 in the same cycle.
   - Required: next cycle o_issue_valid=1 and rs2_data=42.
5. **Head-of-line blocking.**
   - Stimulus: entry A waits on tag 0x01; entry B is fully valid.
   - Required: no issue until CDB tag 0x01 arrives; then A issues, followed by B.
6. **Simultaneous accept/fire and reset mid-operation.**
   - Stimulus: count=2, dispatch and fire in the same cycle.
   - Required: o_count stays 2.
   - Stimulus: assert rst asynchronously mid-cycle.
   - Required: immediately o_count=0, o_issue_valid=0.
